uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter (its trmt/tx_data/done byte interface) between NUM_REQ byte requesters using round-robin arbitration. It captures the winning requester's byte, issues a one-cycle trmt, and waits for the transmitter's done pulse before arbitrating again. It sits between the command/telemetry sources and the UART transmit datapath, and is the only block driving that transmitter.

## Interface
- NUM_REQ, 4: number of requesters; any value 2..8, power of two not required
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  requester i wants to send a byte; held until gnt[i]
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]; stable while req[i] high
- req_lock  in  NUM_REQ  requester i asks to keep ownership after its byte (used only with UART_TX_ARB_LOCK_EN)
- gnt  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
- owner  out  $clog2(NUM_REQ)  index of current/last granted requester
- busy  out  1  high in every state except IDLE
- trmt  out  1  one-cycle start pulse to UART transmitter
- tx_data  out  8  registered byte to UART transmitter, stable from trmt until done
- tx_done  in  1  transmitter's done pulse (one cycle, byte fully shifted)

## Operation
- Reset values: gnt=0, owner=0, busy=0, trmt=0, tx_data=8'h00, state IDLE, last-owner pointer=NUM_REQ-1 (req[0] highest priority after reset).
- States: IDLE, SEND, WAIT, HOLD (HOLD reachable only with lock enabled).
- IDLE: if req!=0, winner w = first set req scanning from (last+1) mod NUM_REQ upward with wrap; on the edge: tx_data<=req_data[w], owner<=w, last<=w, go to SEND. If req==0, stay.
- SEND (exactly one cycle): trmt=1, gnt[w]=1, busy=1; go to WAIT.
- WAIT: hold tx_data/owner; on tx_done=1 go to IDLE (or HOLD, see Configuration).
- tx_done is ignored in IDLE, SEND and HOLD.
- Requester may drop req or change req_data during its gnt cycle; the byte is already captured. req dropped before grant = withdrawn, no byte sent.
- Requests arriving mid-transfer wait; none are lost while req held.
- Reset mid-transfer: immediate return to reset values; transmitter shares rst so no stale done expected. A done after reset in IDLE is ignored.

## Timing
- req rising in IDLE cycle N -> trmt and gnt in cycle N+1 (latency 1).
- tx_done in cycle M -> IDLE in M+1 -> next trmt no earlier than M+2.
- Simultaneous requests: strict rotation; each requester with continuous req gets one byte per NUM_REQ grants.
- gnt and trmt are always coincident and never assert for two consecutive cycles.

## Configuration
- UART_TX_ARB_LOCK_EN defined: in WAIT with tx_done=1 and req_lock[owner]=1 -> HOLD. In HOLD: if req_lock[owner]=0 -> IDLE; else if req[owner]=1 -> capture req_data[owner], go to SEND (no arbitration, last unchanged); else stay. busy=1 in HOLD. Other requesters are blocked until the lock drops.
- Not defined: req_lock ignored, HOLD never entered, tx_done in WAIT always -> IDLE.

## Structure
- Package uart_tx_arb_pkg: state enum typedef (IDLE, SEND, WAIT, HOLD), byte width constant 8.
- Sub-module uart_rr_pick: combinational round-robin picker (req vector, last pointer -> valid, winner index). The FSM and registers stay in uart_tx_arbiter.

## Test plan
- Reset: rst=1 mid-WAIT -> all outputs 0 next sample, state IDLE; release, req=4'b0001 data 8'hA5 -> trmt+gnt=0001 one cycle later, tx_data=8'hA5.
- Contention: req=4'b1111, each done 20 cycles after trmt -> owner sequence 0,1,2,3,0; trmt spacing 22 cycles.
- Wrap/skip: last=2, req=4'b0011 -> owner 0 granted, then 1.
- Withdraw and stray done: req[1] pulsed during WAIT then dropped -> never granted; tx_done in IDLE -> no state change, no trmt.
- Lock (macro on): req[2]+req_lock[2] for 3 bytes 8'h10,8'h11,8'h12 while req[0] high -> bytes in order on owner 2, then owner 0. Macro off: same stimulus interleaves 2,0,2.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_tx_arb_pkg;

  localparam int unsigned ByteW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait,
    StHold
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping at NumReq.
module uart_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   winner_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    valid_o  = |req_i;
    winner_o = '0;
    idx      = '0;
    // Scan farthest-first so the nearest set bit after last_i is the final assignment.
    for (int k = NumReq; k >= 1; k--) begin
      idx = IdxW'((32'(last_i) + 32'(k)) % NumReq);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NumReq byte requesters.
// Define UART_TX_ARB_LOCK_EN to let a requester keep ownership across bytes via req_lock_i.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = $clog2(NumReq)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_i,
  input  logic [ByteW*NumReq-1:0] req_data_i,
  input  logic [NumReq-1:0]       req_lock_i,
  output logic [NumReq-1:0]       gnt_o,
  output logic [IdxW-1:0]         owner_o,
  output logic                    busy_o,
  output logic                    trmt_o,
  output logic [ByteW-1:0]        tx_data_o,
  input  logic                    tx_done_i
);

  arb_state_e        state_q;
  logic [ByteW-1:0]  tx_data_q;
  logic [IdxW-1:0]   owner_q;
  logic [IdxW-1:0]   last_q;
  logic [NumReq-1:0] gnt_q;
  logic              trmt_q;
  logic              busy_q;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;

  uart_rr_pick #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .winner_o(pick_idx)
  );

`ifndef UART_TX_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tx_data_q <= '0;
      owner_q   <= '0;
      last_q    <= IdxW'(NumReq - 1);
      gnt_q     <= '0;
      trmt_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // gnt/trmt are single-cycle pulses, only raised on entry to StSend.
      trmt_q <= 1'b0;
      gnt_q  <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            tx_data_q <= req_data_i[ByteW*int'(pick_idx) +: ByteW];
            owner_q   <= pick_idx;
            last_q    <= pick_idx;
            gnt_q     <= NumReq'(1) << pick_idx;
            trmt_q    <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= StSend;
          end
        end
        StSend: begin
          state_q <= StWait;
        end
        StWait: begin
          if (tx_done_i) begin
`ifdef UART_TX_ARB_LOCK_EN
            if (req_lock_i[owner_q]) begin
              state_q <= StHold;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
`endif
          end
        end
        StHold: begin
`ifdef UART_TX_ARB_LOCK_EN
          if (!req_lock_i[owner_q]) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (req_i[owner_q]) begin
            // Locked owner re-sends without arbitration; last_q stays put.
            tx_data_q <= req_data_i[ByteW*int'(owner_q) +: ByteW];
            gnt_q     <= NumReq'(1) << owner_q;
            trmt_q    <= 1'b1;
            state_q   <= StSend;
          end
`else
          state_q <= StIdle;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign owner_o   = owner_q;
  assign busy_o    = busy_q;
  assign trmt_o    = trmt_q;
  assign tx_data_o = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a rotation-rule reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   req_lock;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic           busy;
  logic           trmt;
  logic [7:0]     tx_data;
  logic           tx_done;

  logic [7:0] dat [N];

  int n_vec, n_err, cyc;
  int m_last, m_owner;
  bit m_hold;
  logic [7:0] m_byte;
  int t_gnt, t_prev;

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = dat[i];
  end

  uart_tx_arbiter #(.NumReq(N)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .req_data_i(req_data),
    .req_lock_i(req_lock),
    .gnt_o     (gnt),
    .owner_o   (owner),
    .busy_o    (busy),
    .trmt_o    (trmt),
    .tx_data_o (tx_data),
    .tx_done_i (tx_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next owner by the rules: a held lock keeps the owner, otherwise rotate after last.
  function automatic int model_pick();
    if (m_hold && req_lock[m_owner]) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (req[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_grant(input string tag, input int exp_w);
    bit found;
    int w;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      found = (trmt === 1'b1);
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
    if (found) begin
      w = model_pick();
      if (exp_w >= 0) check({tag, "_owner_dir"}, 32'(owner), 32'(exp_w));
      check({tag, "_gnt"}, 32'(gnt), (w < 0) ? 32'd0 : (32'd1 << w));
      check({tag, "_owner"}, 32'(owner), 32'(w));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (w >= 0) begin
        check({tag, "_data"}, 32'(tx_data), 32'(dat[w]));
        m_last  = w;
        m_owner = w;
        m_byte  = dat[w];
      end
      m_hold = 1'b0;
      t_prev = t_gnt;
      t_gnt  = cyc;
    end
  endtask

  // Called in the trmt cycle; done arrives d cycles after trmt.
  task automatic finish_xfer(input string tag, input int d);
    step();
    check({tag, "_pulse"}, 32'({trmt, gnt}), 32'd0);
    for (int i = 1; i < d; i++) step();
    check({tag, "_txhold"}, 32'(tx_data), 32'(m_byte));
    tx_done = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
    m_hold = req_lock[m_owner];
`endif
    step();
    tx_done = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), 32'(m_hold));
  endtask

  initial begin
    int exp_lk [4];
    int sent2, seen, t0, ri;
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1; req = '0; req_lock = '0; tx_done = 1'b0;
    for (int i = 0; i < N; i++) dat[i] = 8'h00;
    m_last = N - 1; m_owner = 0; m_hold = 1'b0; m_byte = 8'h00; t_gnt = 0; t_prev = 0;

    step(); step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trmt", 32'(trmt), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    rst = 1'b0;

    // All four contend continuously; done 20 cycles after each trmt.
    for (int i = 0; i < N; i++) dat[i] = 8'(8'h30 + i);
    req = '1;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr", g % N);
      if (g > 0) check("rr_gap", 32'(t_gnt - t_prev), 32'd22);
      if (g == 4) req = '0;
      finish_xfer("rr", 20);
    end

    // Reset in the middle of a transfer.
    dat[0] = 8'hA5; req = 4'b0001;
    wait_grant("rst_pre", 0);
    req = '0;
    step(); step(); step();
    rst = 1'b1;
    step();
    check("rstw_gnt", 32'(gnt), 32'd0);
    check("rstw_owner", 32'(owner), 32'd0);
    check("rstw_busy", 32'(busy), 32'd0);
    check("rstw_trmt", 32'(trmt), 32'd0);
    check("rstw_txdata", 32'(tx_data), 32'd0);
    m_last = N - 1; m_owner = 0; m_hold = 1'b0;
    step();
    rst = 1'b0;
    step();
    req = 4'b0001; t0 = cyc;
    wait_grant("rst_post", 0);
    check("rst_post_lat", 32'(t_gnt - t0), 32'd1);
    req = '0;
    finish_xfer("rst_post", 4);

    // Stray done in idle.
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("stray_busy", 32'(busy), 32'd0);
    check("stray_trmt", 32'(trmt), 32'd0);

    // Requester 1 appears during WAIT and withdraws before it could win.
    dat[0] = 8'h3C; req = 4'b0001;
    wait_grant("wd", 0);
    req = '0;
    step();
    dat[1] = 8'hEE; req[1] = 1'b1;
    step(); step();
    req[1] = 1'b0;
    step(); step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("wd_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen += int'(trmt);
    end
    check("wd_none", 32'(seen), 32'd0);

    // Wrap and skip: last=2, then 0 and 1 request together.
    dat[2] = 8'h77; req = 4'b0100;
    wait_grant("wrap_a", 2);
    req = '0;
    finish_xfer("wrap_a", 3);
    dat[0] = 8'h01; dat[1] = 8'h02; req = 4'b0011;
    wait_grant("wrap_b", 0);
    req[0] = 1'b0;
    finish_xfer("wrap_b", 3);
    wait_grant("wrap_c", 1);
    req[1] = 1'b0;
    finish_xfer("wrap_c", 3);

    // Requester 2 sends three bytes with lock while requester 0 waits.
`ifdef UART_TX_ARB_LOCK_EN
    exp_lk = '{2, 2, 2, 0};
`else
    exp_lk = '{2, 0, 2, 2};
`endif
    sent2 = 0;
    dat[0] = 8'h5A; dat[2] = 8'h10; req_lock = 4'b0100; req = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      wait_grant("lock", exp_lk[g]);
      if (m_owner == 2) begin
        req[2] = 1'b0;
        sent2++;
      end else begin
        req[0] = 1'b0;
      end
      finish_xfer("lock", 3);
      if (sent2 < 3 && !req[2]) begin
        dat[2] = 8'(8'h10 + sent2);
        req[2] = 1'b1;
      end else if (sent2 == 3) begin
        req_lock = '0;
      end
    end

    // Randomized traffic.
    req = '0; req_lock = '0;
    for (int it = 0; it < 40; it++) begin
      if (req == '0) begin
        ri = int'($urandom_range(N - 1));
        dat[ri] = 8'($urandom);
        req[ri] = 1'b1;
      end
      wait_grant("rand", -1);
      if ($urandom_range(3) != 0) req[m_owner] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (i != m_owner && !req[i] && $urandom_range(2) == 0) begin
          dat[i] = 8'($urandom);
          req[i] = 1'b1;
        end else if (i != m_owner && req[i] && $urandom_range(7) == 0) begin
          req[i] = 1'b0;
        end
      end
      finish_xfer("rand", int'($urandom_range(6, 2)));
    end
    req = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
